// File: rtl/de_pkg.sv
// Shared definitions for the decode stage: field widths, RV32I opcode constants,
// the 6-bit decoded-operation enum and the instruction decoder.
package de_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned OP_W      = 6;

    // Latch widths at the default 32-bit datapath.
    localparam int unsigned FE_LATCH_W = 1 + INST_W + 3 * 32;                 // 129
    localparam int unsigned WB_W       = 1 + REG_IDX_W + 32;                  // 38
    localparam int unsigned DE_LATCH_W = 1 + OP_W + REG_IDX_W + 1 + 6 * 32;   // 205

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // OP_ILLEGAL is zero so an all-zero bubble decodes as "nothing".
    typedef enum logic [OP_W-1:0] {
        OP_ILLEGAL = 6'd0, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LW, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef struct packed {
        op_e                  op;
        logic [REG_IDX_W-1:0] rd;         // zero unless the op writes rd
        logic                 writes_rd;
        logic                 use_rs1;
        logic                 use_rs2;
        logic [31:0]          imm;
    } dec_t;

    function automatic dec_t decode(input logic [INST_W-1:0] inst);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm_i;
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        d.op        = OP_ILLEGAL;
        d.rd        = '0;
        d.writes_rd = 1'b0;
        d.use_rs1   = 1'b0;
        d.use_rs2   = 1'b0;
        d.imm       = '0;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.op        = (inst[6:0] == OPC_LUI) ? OP_LUI : OP_AUIPC;
                d.writes_rd = 1'b1;
                d.imm       = {inst[31:12], 12'h000};
            end
            OPC_JAL: begin
                d.op        = OP_JAL;
                d.writes_rd = 1'b1;
                d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_JALR: if (f3 == 3'b000) begin
                d.op = OP_JALR; d.writes_rd = 1'b1; d.use_rs1 = 1'b1; d.imm = imm_i;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  d.op = OP_BEQ;
                    3'b001:  d.op = OP_BNE;
                    3'b100:  d.op = OP_BLT;
                    3'b101:  d.op = OP_BGE;
                    3'b110:  d.op = OP_BLTU;
                    3'b111:  d.op = OP_BGEU;
                    default: d.op = OP_ILLEGAL;
                endcase
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LOAD: if (f3 == 3'b010) begin
                d.op = OP_LW; d.writes_rd = 1'b1; d.use_rs1 = 1'b1; d.imm = imm_i;
            end
            OPC_STORE: if (f3 == 3'b010) begin
                d.op = OP_SW; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
                d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_OPIMM: begin
                case (f3)
                    3'b000:  d.op = OP_ADDI;
                    3'b010:  d.op = OP_SLTI;
                    3'b011:  d.op = OP_SLTIU;
                    3'b100:  d.op = OP_XORI;
                    3'b110:  d.op = OP_ORI;
                    3'b111:  d.op = OP_ANDI;
                    3'b001:  d.op = (f7 == 7'b0000000) ? OP_SLLI : OP_ILLEGAL;
                    default: d.op = (f7 == 7'b0000000) ? OP_SRLI :
                                    (f7 == 7'b0100000) ? OP_SRAI : OP_ILLEGAL;
                endcase
                d.writes_rd = 1'b1; d.use_rs1 = 1'b1; d.imm = imm_i;
            end
            OPC_OP: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d.op = OP_ADD;
                        3'b001:  d.op = OP_SLL;
                        3'b010:  d.op = OP_SLT;
                        3'b011:  d.op = OP_SLTU;
                        3'b100:  d.op = OP_XOR;
                        3'b101:  d.op = OP_SRL;
                        3'b110:  d.op = OP_OR;
                        default: d.op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    d.op = (f3 == 3'b000) ? OP_SUB : (f3 == 3'b101) ? OP_SRA : OP_ILLEGAL;
                end
                d.writes_rd = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
            end
            default: d.op = OP_ILLEGAL;
        endcase
        // Illegal encodings (including bad funct fields) read and write nothing.
        if (d.op == OP_ILLEGAL) begin
            d.writes_rd = 1'b0; d.use_rs1 = 1'b0; d.use_rs2 = 1'b0; d.imm = '0;
        end
        d.rd = d.writes_rd ? inst[11:7] : '0;
        return d;
    endfunction

endpackage

// File: rtl/de_regfile.sv
// Architectural register file: two combinational read ports, one write port.
// Ports: clk, reset (async, active-high); rs1_addr/rs2_addr -> rs1_data/rs2_data;
// wr_en/wr_addr/wr_data write port. x0 reads zero and ignores writes; a read of the
// register being written this cycle returns wr_data (write-through).
module de_regfile import de_pkg::*; #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned REGNO = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic [DBITS-1:0]     rs1_data,
    output logic [DBITS-1:0]     rs2_data,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [DBITS-1:0]     wr_data
);

    logic [DBITS-1:0] regs_q [REGNO];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGNO; i++) regs_q[i] <= '0;
        end else if (wr_en && wr_addr != '0 && 32'(wr_addr) < REGNO) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0 && 32'(rs1_addr) < REGNO) begin
            rs1_data = (wr_en && wr_addr == rs1_addr) ? wr_data : regs_q[rs1_addr];
        end
        if (rs2_addr != '0 && 32'(rs2_addr) < REGNO) begin
            rs2_data = (wr_en && wr_addr == rs2_addr) ? wr_data : regs_q[rs2_addr];
        end
    end

endmodule

// File: rtl/de_stage.sv
// Decode stage: decodes the FE latch, reads operands, tracks in-flight writers with a
// busy scoreboard and stalls FE on RAW/WAW hazards. A flush from AGEX squashes both
// the incoming instruction and the writer currently held in DE_latch.
// Ports: clk, reset (async, active-high); from_FE_latch {valid,inst,pc,pcplus,inst_count};
// from_AGEX_to_DE flush; from_WB_to_DE {wr_en,wr_reg,wr_data}; from_DE_to_FE stall;
// DE_latch_out {valid,op,rd,wr_en,rs1_val,rs2_val,imm,pc,pcplus,inst_count}.
module de_stage import de_pkg::*; #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned REGNO = 32
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [INST_W+3*DBITS:0]                  from_FE_latch,
    input  logic                                     from_AGEX_to_DE,
    input  logic [REG_IDX_W+DBITS:0]                 from_WB_to_DE,
    output logic                                     from_DE_to_FE,
    output logic [OP_W+REG_IDX_W+1+6*DBITS:0]        DE_latch_out
);

    localparam int unsigned LatW  = OP_W + REG_IDX_W + 2 + 6 * DBITS;
    localparam int unsigned WrPos = 6 * DBITS;
    localparam int unsigned RdLsb = 6 * DBITS + 1;

    logic                 fe_valid;
    logic [INST_W-1:0]    inst;
    logic [DBITS-1:0]     fe_pc, fe_pcplus, fe_count;
    logic                 wb_en;
    logic [REG_IDX_W-1:0] wb_reg;
    logic [DBITS-1:0]     wb_data;
    logic                 flush;

    assign fe_valid  = from_FE_latch[INST_W+3*DBITS];
    assign inst      = from_FE_latch[INST_W+3*DBITS-1 -: INST_W];
    assign fe_pc     = from_FE_latch[3*DBITS-1 -: DBITS];
    assign fe_pcplus = from_FE_latch[2*DBITS-1 -: DBITS];
    assign fe_count  = from_FE_latch[DBITS-1:0];
    assign wb_en     = from_WB_to_DE[REG_IDX_W+DBITS];
    assign wb_reg    = from_WB_to_DE[REG_IDX_W+DBITS-1 -: REG_IDX_W];
    assign wb_data   = from_WB_to_DE[DBITS-1:0];
    assign flush     = from_AGEX_to_DE;

    dec_t                 dec;
    logic                 dec_wr_en;
    logic [REG_IDX_W-1:0] rs1, rs2;
    logic [DBITS-1:0]     rf_rs1, rf_rs2;

    assign dec       = decode(inst);
    assign dec_wr_en = dec.writes_rd && (dec.rd != '0);
    assign rs1       = inst[19:15];
    assign rs2       = inst[24:20];

    de_regfile #(.DBITS(DBITS), .REGNO(REGNO)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rf_rs1),
        .rs2_data (rf_rs2),
        .wr_en    (wb_en),
        .wr_addr  (wb_reg),
        .wr_data  (wb_data)
    );

    logic [LatW-1:0]  latch_q, latch_d;
    logic [REGNO-1:0] busy_q, busy_d;
    logic [REGNO-1:0] wb_clr, squash_clr, issue_set, busy_eff;
    logic             hazard, issue;
    logic             lat_valid, lat_wr;
    logic [REG_IDX_W-1:0] lat_rd;

    assign lat_valid = latch_q[LatW-1];
    assign lat_wr    = latch_q[WrPos];
    assign lat_rd    = latch_q[RdLsb +: REG_IDX_W];

    // A register retired by WB this cycle is already free for the hazard check.
    assign wb_clr   = wb_en ? (REGNO'(1) << wb_reg) : '0;
    assign busy_eff = busy_q & ~wb_clr;

    always_comb begin
        hazard = fe_valid && (
            (dec.use_rs1 && rs1 != '0 && |(busy_eff & (REGNO'(1) << rs1))) ||
            (dec.use_rs2 && rs2 != '0 && |(busy_eff & (REGNO'(1) << rs2))) ||
            (dec_wr_en && |(busy_eff & (REGNO'(1) << dec.rd))));
        issue = fe_valid && !hazard && !flush;
    end

    assign from_DE_to_FE = hazard && !flush && !reset;

    always_comb begin
        latch_d = '0;
        if (issue) begin
            latch_d = {1'b1, dec.op, dec.rd, dec_wr_en,
                       dec.use_rs1 ? rf_rs1 : '0,
                       dec.use_rs2 ? rf_rs2 : '0,
                       DBITS'($signed(dec.imm)),
                       fe_pc, fe_pcplus, fe_count};
        end
        // The flushed writer in DE_latch will never reach WB, so free its rd here.
        squash_clr = (flush && lat_valid && lat_wr) ? (REGNO'(1) << lat_rd) : '0;
        issue_set  = (issue && dec_wr_en) ? (REGNO'(1) << dec.rd) : '0;
        busy_d     = (busy_q & ~wb_clr & ~squash_clr) | issue_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_q <= '0;
            busy_q  <= '0;
        end else begin
            latch_q <= latch_d;
            busy_q  <= busy_d;
        end
    end

    assign DE_latch_out = latch_q;

endmodule

// File: tb/tb_de_stage.sv
// Bench for de_stage: directed scenarios followed by a random run, all checked against
// an instruction-level model (encoder-side knowledge of op/imm, register array, busy set).
module tb_de_stage;
    import de_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [128:0] fe;
    logic         flush;
    logic [37:0]  wb;
    logic         stall;
    logic [204:0] lat;

    de_stage #(.DBITS(32), .REGNO(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .from_FE_latch   (fe),
        .from_AGEX_to_DE (flush),
        .from_WB_to_DE   (wb),
        .from_DE_to_FE   (stall),
        .DE_latch_out    (lat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        op_e         op;
        int          rd, rs1, rs2;
        bit          u1, u2, wr;
        logic [31:0] imm;
    } ins_t;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] mregs [32];
    bit          mbusy [32];
    bit          m_lv, m_lw;
    int          m_lrd;
    bit          last_stall;

    task automatic chk(input string tag, input logic [204:0] obs, input logic [204:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin mregs[r] = '0; mbusy[r] = 1'b0; end
        m_lv = 1'b0; m_lw = 1'b0; m_lrd = 0; last_stall = 1'b0;
    endtask

    // Encode an instruction and record what decode must produce for it.
    function automatic ins_t mk(op_e op, int rd, int rs1, int rs2, int imm);
        ins_t r;
        logic [31:0] v;
        logic [4:0] d, a, b;
        logic [2:0] f3;
        v = imm; d = 5'(rd); a = 5'(rs1); b = 5'(rs2);
        r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.u1 = 1'b0; r.u2 = 1'b0; r.wr = 1'b0; r.imm = '0; r.inst = '0;
        case (op)
            OP_LUI:   begin r.inst = {v[19:0], d, 7'b0110111}; r.imm = v << 12; r.wr = 1; end
            OP_AUIPC: begin r.inst = {v[19:0], d, 7'b0010111}; r.imm = v << 12; r.wr = 1; end
            OP_JAL: begin
                r.inst = {v[20], v[10:1], v[11], v[19:12], d, 7'b1101111}; r.imm = v; r.wr = 1;
            end
            OP_JALR: begin
                r.inst = {v[11:0], a, 3'b000, d, 7'b1100111}; r.imm = v; r.wr = 1; r.u1 = 1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGEU: begin
                f3 = (op == OP_BEQ) ? 3'b000 : (op == OP_BNE) ? 3'b001 :
                     (op == OP_BLT) ? 3'b100 : 3'b111;
                r.inst = {v[12], v[10:5], b, a, f3, v[4:1], v[11], 7'b1100011};
                r.imm = v; r.u1 = 1; r.u2 = 1;
            end
            OP_LW: begin
                r.inst = {v[11:0], a, 3'b010, d, 7'b0000011}; r.imm = v; r.wr = 1; r.u1 = 1;
            end
            OP_SW: begin
                r.inst = {v[11:5], b, a, 3'b010, v[4:0], 7'b0100011}; r.imm = v;
                r.u1 = 1; r.u2 = 1;
            end
            OP_ADDI, OP_XORI: begin
                f3 = (op == OP_ADDI) ? 3'b000 : 3'b100;
                r.inst = {v[11:0], a, f3, d, 7'b0010011}; r.imm = v; r.wr = 1; r.u1 = 1;
            end
            OP_SLLI: begin
                r.inst = {7'b0000000, v[4:0], a, 3'b001, d, 7'b0010011};
                r.imm = v & 31; r.wr = 1; r.u1 = 1;
            end
            OP_SRAI: begin
                r.inst = {7'b0100000, v[4:0], a, 3'b101, d, 7'b0010011};
                r.imm = 1024 + (v & 31); r.wr = 1; r.u1 = 1;
            end
            OP_ADD, OP_SUB, OP_SRA: begin
                r.inst = {(op == OP_ADD) ? 7'b0000000 : 7'b0100000, b, a,
                          (op == OP_SRA) ? 3'b101 : 3'b000, d, 7'b0110011};
                r.wr = 1; r.u1 = 1; r.u2 = 1;
            end
            default: begin r.op = OP_ILLEGAL; r.inst = {v[24:0], 7'b0001011}; end
        endcase
        return r;
    endfunction

    function automatic ins_t rand_ins();
        op_e ops [18] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGEU,
                          OP_LW, OP_SW, OP_ADDI, OP_XORI, OP_SLLI, OP_SRAI, OP_ADD, OP_SUB,
                          OP_SRA, OP_ILLEGAL};
        op_e op;
        int imm;
        op = ops[$urandom_range(0, 17)];
        case (op)
            OP_LUI, OP_AUIPC: imm = int'($urandom_range(0, 1048575));
            OP_JAL: imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGEU: imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
            OP_SLLI, OP_SRAI: imm = int'($urandom_range(0, 31));
            OP_ILLEGAL: imm = int'($urandom);
            default: imm = int'($urandom_range(0, 4095)) - 2048;
        endcase
        return mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), imm);
    endfunction

    function automatic logic [31:0] rd_model(int r, bit we, int wr_reg, logic [31:0] wd);
        if (r == 0) return '0;
        if (we && wr_reg == r) return wd;
        return mregs[r];
    endfunction

    // One clock cycle: drive inputs, check stall, clock, check the latch, advance model.
    task automatic step(input bit v, input ins_t in, input logic [31:0] pc, input bit fl,
                        input bit we, input int wr_reg, input logic [31:0] wd, input string tag);
        logic [204:0] exp_lat;
        logic [31:0]  r1, r2;
        bit           eff [32];
        bit           haz, e_stall, wen, iss;
        fe    = {v, in.inst, pc, pc + 32'd4, ~pc};
        flush = fl;
        wb    = {we, 5'(wr_reg), wd};
        for (int r = 0; r < 32; r++) eff[r] = mbusy[r] && !(we && wr_reg == r);
        wen = in.wr && in.rd != 0;
        haz = v && ((in.u1 && in.rs1 != 0 && eff[in.rs1]) ||
                    (in.u2 && in.rs2 != 0 && eff[in.rs2]) || (wen && eff[in.rd]));
        e_stall = haz && !fl;
        iss = v && !haz && !fl;
        r1 = in.u1 ? rd_model(in.rs1, we, wr_reg, wd) : '0;
        r2 = in.u2 ? rd_model(in.rs2, we, wr_reg, wd) : '0;
        exp_lat = iss ? {1'b1, 6'(in.op), 5'(in.wr ? in.rd : 0), wen, r1, r2, in.imm,
                         pc, pc + 32'd4, ~pc} : '0;
        #3;
        chk({tag, " stall"}, 205'(stall), 205'(e_stall));
        @(posedge clk);
        #1;
        if (we && wr_reg != 0) mregs[wr_reg] = wd;
        if (we) mbusy[wr_reg] = 1'b0;
        if (fl && m_lv && m_lw) mbusy[m_lrd] = 1'b0;
        if (iss && wen) mbusy[in.rd] = 1'b1;
        m_lv = iss; m_lw = iss && wen; m_lrd = in.rd;
        last_stall = e_stall;
        chk({tag, " latch"}, lat, exp_lat);
    endtask

    ins_t nop, cur;
    bit   cur_v, rfl, rwe;
    int   rreg;
    logic [31:0] cur_pc;
    int   bq [$];

    initial begin
        nop = mk(OP_ILLEGAL, 0, 0, 0, 0);
        reset = 1'b1; fe = '0; flush = 1'b0; wb = '0;
        model_reset();
        #1;
        chk("reset latch", lat, '0);
        chk("reset stall", 205'(stall), '0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Back-to-back RAW on x1, released by WB.
        step(1, mk(OP_ADDI, 1, 0, 0, 5), 32'h100, 0, 0, 0, 0, "raw addi");
        step(1, mk(OP_ADD, 2, 1, 1, 0), 32'h104, 0, 0, 0, 0, "raw hold0");
        chk("raw stalled", 205'(stall), 205'(1));
        step(1, mk(OP_ADD, 2, 1, 1, 0), 32'h104, 0, 0, 0, 0, "raw hold1");
        step(1, mk(OP_ADD, 2, 1, 1, 0), 32'h104, 0, 1, 1, 32'd5, "raw wb");
        chk("raw rs1", 205'(lat[191:160]), 205'(5));
        chk("raw rs2", 205'(lat[159:128]), 205'(5));
        chk("raw op", 205'(lat[203:198]), 205'(OP_ADD));

        // Write-through on x3.
        step(1, mk(OP_ADD, 7, 3, 0, 0), 32'h108, 0, 1, 3, 32'hDEADBEEF, "wthru");
        chk("wthru rs1", 205'(lat[191:160]), 205'(32'hDEADBEEF));

        // Flush squashes ADDI x4 in DE_latch; a reader of x4 is then not stalled.
        step(1, mk(OP_ADDI, 4, 0, 0, 1), 32'h10c, 0, 0, 0, 0, "flush addi");
        step(1, mk(OP_ADD, 9, 0, 0, 0), 32'h110, 1, 0, 0, 0, "flush");
        chk("flush latch", lat, '0);
        step(1, mk(OP_ADD, 5, 4, 4, 0), 32'h114, 0, 0, 0, 0, "flush after");
        chk("flush after valid", 205'(lat[204]), 205'(1));

        // Flush and hazard together.
        step(1, mk(OP_ADDI, 6, 0, 0, 2), 32'h118, 0, 0, 0, 0, "fh addi");
        step(1, mk(OP_ADD, 8, 6, 6, 0), 32'h11c, 1, 0, 0, 0, "fh both");
        chk("fh latch", lat, '0);

        // Immediate formats: SW negative offset, JAL +2048.
        step(1, mk(OP_SW, 0, 6, 5, -4), 32'h120, 0, 1, 5, 32'd77, "sw");
        chk("sw op", 205'(lat[203:198]), 205'(OP_SW));
        chk("sw imm", 205'(lat[127:96]), 205'(32'hFFFFFFFC));
        chk("sw wr_en", 205'(lat[192]), '0);
        step(1, mk(OP_JAL, 1, 0, 0, 2048), 32'h124, 0, 0, 0, 0, "jal");
        chk("jal imm", 205'(lat[127:96]), 205'(32'h00000800));
        chk("jal rd", 205'(lat[197:193]), 205'(1));

        // Random traffic; FE holds its instruction while stalled.
        cur = nop; cur_v = 1'b0; cur_pc = '0;
        for (int k = 0; k < 400; k++) begin
            if (!last_stall) begin
                cur_v  = ($urandom_range(0, 99) < 85);
                cur    = rand_ins();
                cur_pc = $urandom;
            end
            rfl = ($urandom_range(0, 99) < 8);
            rwe = 1'b0; rreg = 0;
            if ($urandom_range(0, 99) < 45) begin
                bq.delete();
                for (int r = 1; r < 32; r++) if (mbusy[r]) bq.push_back(r);
                rwe  = 1'b1;
                rreg = (bq.size() > 0) ? bq[$urandom_range(0, bq.size() - 1)]
                                       : int'($urandom_range(0, 7));
            end
            step(cur_v, cur, cur_pc, rfl, rwe, rreg, $urandom, "rand");
        end

        // Reset in the middle of a stall clears everything without a clock edge.
        step(1, mk(OP_ADDI, 10, 0, 0, 3), 32'h200, 0, 0, 0, 0, "rst addi");
        step(1, mk(OP_ADD, 11, 10, 10, 0), 32'h204, 0, 0, 0, 0, "rst hold");
        chk("rst pre stall", 205'(stall), 205'(1));
        reset = 1'b1;
        #1;
        chk("rst async latch", lat, '0);
        chk("rst async stall", 205'(stall), '0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        step(1, mk(OP_ADD, 11, 10, 10, 0), 32'h204, 0, 0, 0, 0, "rst after");
        chk("rst after valid", 205'(lat[204]), 205'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
